// File: rtl/spi_flash_sequencer.sv
// SPI NOR command sequencer (read / page program / 4K sector erase) in front of a byte-stream SPI master.
// Optional SPI_FLASH_WAKE_EN: send release-from-deep-power-down (0xAB) and wait tRES1 after reset.
//
// state     | meaning
// IDLE      | waiting for a command, cmd_ready high
// WREN      | sending write-enable 0x06
// GAP       | chip select high for CS_GAP cycles between transactions
// OPCODE    | sending command opcode
// ADDR      | sending 24-bit address, MSB first
// DATA      | read or program data bytes
// POLL      | read-status 0x05 + dummy byte, check WIP
// DONE      | one-cycle completion pulse
// WAKE_INIT | wake build: one cycle with chip select high after reset
// WAKE      | wake build: sending 0xAB
// WAKE_GAP  | wake build: tRES1 wait with chip select high
module spi_flash_sequencer #(
   parameter int CS_GAP   = 4,
   parameter int POLL_MAX = 65535
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [23:0] cmd_addr,
   input  logic [15:0] cmd_len,
   input  logic        wr_valid,
   input  logic [7:0]  wr_data,
   output logic        wr_ready,
   output logic        rd_valid,
   output logic [7:0]  rd_data,
   input  logic        rd_ready,
   output logic        done,
   output logic        error,
   output logic        spi_tx_valid,
   output logic [7:0]  spi_tx_data,
   input  logic        spi_tx_ready,
   input  logic        spi_rx_valid,
   input  logic [7:0]  spi_rx_data,
   output logic        spi_rx_ready,
   output logic        spi_ss
);

   localparam int          PW        = (POLL_MAX < 2) ? 1 : $clog2(POLL_MAX + 1);
   localparam logic [15:0] GAP_LOAD  = 16'(CS_GAP - 1);
   localparam logic [15:0] WAKE_LOAD = 16'd2047;

   typedef enum logic [3:0] {
      S_IDLE, S_WREN, S_GAP, S_OPCODE, S_ADDR, S_DATA, S_POLL, S_DONE,
      S_WAKE_INIT, S_WAKE, S_WAKE_GAP
   } state_t;

`ifdef SPI_FLASH_WAKE_EN
   localparam state_t RESET_STATE = S_WAKE_INIT;
`else
   localparam state_t RESET_STATE = S_IDLE;
`endif

   state_t          state, state_next;
   logic            tx_sent;
   logic [1:0]      byte_idx;
   logic [15:0]     data_cnt;
   logic [PW-1:0]   poll_cnt;
   logic [15:0]     gap_cnt;
   logic            gap_to_opcode;
   logic [1:0]      op_q;
   logic [23:0]     addr_q;
   logic [15:0]     len_q;
   logic            ss_q;
   logic            done_q;
   logic            error_q;

   logic            accept;
   logic            is_prog;
   logic            is_erase;
   logic            byte_state;
   logic            byte_done;
   logic            poll_timeout;
   logic            ss_low_next;
   logic [7:0]      tx_byte;
   logic [7:0]      opcode;
   logic [15:0]     data_inc;
   logic [PW-1:0]   poll_inc;

   assign accept   = cmd_valid && (state == S_IDLE);
   assign is_prog  = (op_q == 2'd1);
   assign is_erase = (op_q == 2'd2);
   assign data_inc = data_cnt + 16'd1;
   assign poll_inc = poll_cnt + PW'(1);

   assign byte_state  = state inside {S_WREN, S_OPCODE, S_ADDR, S_DATA, S_POLL, S_WAKE};
   assign ss_low_next = state_next inside {S_WREN, S_OPCODE, S_ADDR, S_DATA, S_POLL, S_WAKE};

   always_comb begin
      opcode = 8'h03;
      case (op_q)
         2'd1:    opcode = 8'h02;
         2'd2:    opcode = 8'h20;
         default: opcode = 8'h03;
      endcase
   end

   always_comb begin
      tx_byte = 8'h00;
      case (state)
         S_WREN:   tx_byte = 8'h06;
         S_OPCODE: tx_byte = opcode;
         S_ADDR: begin
            case (byte_idx)
               2'd0:    tx_byte = addr_q[23:16];
               2'd1:    tx_byte = addr_q[15:8];
               default: tx_byte = addr_q[7:0];
            endcase
         end
         S_POLL:   tx_byte = (byte_idx == 2'd0) ? 8'h05 : 8'h00;
         S_WAKE:   tx_byte = 8'hAB;
         default:  tx_byte = 8'h00;
      endcase
   end

   always_comb begin
      state_next   = state;
      spi_tx_valid = 1'b0;
      spi_tx_data  = 8'h00;
      spi_rx_ready = 1'b0;
      rd_valid     = 1'b0;
      wr_ready     = 1'b0;
      byte_done    = 1'b0;
      poll_timeout = 1'b0;

      // one byte outstanding: offer tx until taken, then consume its rx
      if (byte_state) begin
         spi_tx_valid = !tx_sent;
         spi_tx_data  = tx_byte;
         spi_rx_ready = tx_sent;
         if (state == S_DATA) begin
            if (is_prog) begin
               spi_tx_valid = !tx_sent && wr_valid;
               spi_tx_data  = wr_data;
               wr_ready     = !tx_sent && spi_tx_ready;
            end else begin
               spi_rx_ready = tx_sent && rd_ready;
               rd_valid     = tx_sent && spi_rx_valid;
            end
         end
         byte_done = tx_sent && spi_rx_valid && spi_rx_ready;
      end

      case (state)
         S_IDLE: begin
            if (cmd_valid) begin
               case (cmd_op)
                  2'd0:       state_next = S_OPCODE;
                  2'd1, 2'd2: state_next = S_WREN;
                  default:    state_next = S_IDLE;
               endcase
            end
         end
         S_WREN:   if (byte_done) state_next = S_GAP;
         S_GAP:    if (gap_cnt == 16'd0) state_next = gap_to_opcode ? S_OPCODE : S_POLL;
         S_OPCODE: if (byte_done) state_next = S_ADDR;
         S_ADDR: begin
            if (byte_done && byte_idx == 2'd2) begin
               if (is_erase)
                  state_next = S_GAP;
               else if (len_q == 16'd0)
                  state_next = is_prog ? S_GAP : S_DONE;
               else
                  state_next = S_DATA;
            end
         end
         S_DATA: begin
            if (byte_done && data_inc == len_q)
               state_next = is_prog ? S_GAP : S_DONE;
         end
         S_POLL: begin
            if (byte_done && byte_idx == 2'd1) begin
               if (!spi_rx_data[0]) begin
                  state_next = S_DONE;
               end else if (poll_inc == PW'(POLL_MAX)) begin
                  poll_timeout = 1'b1;
                  state_next   = S_DONE;
               end else begin
                  state_next = S_GAP;
               end
            end
         end
         S_DONE:      state_next = S_IDLE;
         S_WAKE_INIT: state_next = S_WAKE;
         S_WAKE:      if (byte_done) state_next = S_WAKE_GAP;
         S_WAKE_GAP:  if (gap_cnt == 16'd0) state_next = S_IDLE;
         default:     state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= RESET_STATE;
         tx_sent       <= 1'b0;
         byte_idx      <= 2'd0;
         data_cnt      <= 16'd0;
         poll_cnt      <= '0;
         gap_cnt       <= 16'd0;
         gap_to_opcode <= 1'b0;
         op_q          <= 2'd0;
         addr_q        <= 24'd0;
         len_q         <= 16'd0;
         ss_q          <= 1'b1;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
      end else begin
         state  <= state_next;
         ss_q   <= !ss_low_next;
         done_q <= (state_next == S_DONE) || (accept && cmd_op == 2'd3);

         if (accept) begin
            op_q     <= cmd_op;
            addr_q   <= cmd_addr;
            len_q    <= cmd_len;
            data_cnt <= 16'd0;
            poll_cnt <= '0;
            error_q  <= (cmd_op == 2'd3);
         end else if (poll_timeout) begin
            error_q <= 1'b1;
         end

         if (spi_tx_valid && spi_tx_ready)
            tx_sent <= 1'b1;
         else if (byte_done)
            tx_sent <= 1'b0;

         if (state_next != state)
            byte_idx <= 2'd0;
         else if (byte_done)
            byte_idx <= byte_idx + 2'd1;

         if (state == S_DATA && byte_done)
            data_cnt <= data_inc;
         if (state == S_POLL && byte_done && byte_idx == 2'd1)
            poll_cnt <= poll_inc;

         // down-counter shared by the inter-transaction gap and the wake wait
         if (state_next == S_GAP && state != S_GAP) begin
            gap_cnt       <= GAP_LOAD;
            gap_to_opcode <= (state == S_WREN);
         end else if (state_next == S_WAKE_GAP && state != S_WAKE_GAP) begin
            gap_cnt <= WAKE_LOAD;
         end else if (gap_cnt != 16'd0) begin
            gap_cnt <= gap_cnt - 16'd1;
         end
      end
   end

   assign cmd_ready = (state == S_IDLE);
   assign done      = done_q;
   assign error     = error_q;
   assign spi_ss    = ss_q;
   assign rd_data   = spi_rx_data;

endmodule
